// File: rtl/boot_rom_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : boot_rom_prefetch
// Function : single-line prefetch buffer in front of the boot ROM; fills an
//            aligned line on a read miss and answers writes with an error.
// Revision : 1.0 - initial release
// ============================================================================
module boot_rom_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  slv_req_i,
    input  logic [ADDR_WIDTH-1:0] slv_add_i,
    input  logic                  slv_wen_i,
    output logic                  slv_gnt_o,
    output logic                  slv_r_valid_o,
    output logic [31:0]           slv_r_rdata_o,
    output logic                  slv_r_opc_o,
    output logic                  rom_req_o,
    output logic [ADDR_WIDTH-1:0] rom_add_o,
    input  logic                  rom_gnt_i,
    input  logic                  rom_r_valid_i,
    input  logic [31:0]           rom_r_rdata_i
);

    localparam int OFFS  = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - OFFS - 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [31:0]      line_mem [LINE_WORDS];
    logic [TAG_W-1:0] tag;
    logic             line_valid;
    logic [OFFS-1:0]  off;
    logic [OFFS:0]    issue_cnt;
    logic [OFFS:0]    ret_cnt;
    logic             flush_pend;

    logic [TAG_W-1:0] req_tag;
    logic [OFFS-1:0]  req_offs;
    logic             addr_lsb_unused;
    logic             accept;
    logic             rd_hit;
    logic             rd_miss;
    logic             wr_acc;
    logic             ret_fire;
    logic             ret_last;

    assign req_tag         = slv_add_i[ADDR_WIDTH-1:OFFS+2];
    assign req_offs        = slv_add_i[OFFS+1:2];
    assign addr_lsb_unused = ^slv_add_i[1:0];

    assign accept    = slv_req_i & (state == IDLE) & rst_ni;
    assign slv_gnt_o = accept;
    // A flush coinciding with a read forces that read down the miss path.
    assign rd_hit    = accept & slv_wen_i & line_valid & ~flush_i & (tag == req_tag);
    assign rd_miss   = accept & slv_wen_i & ~rd_hit;
    assign wr_acc    = accept & ~slv_wen_i;
    assign ret_fire  = (state == FILL) & rom_r_valid_i;
    // ret_cnt never passes LINE_WORDS-1 inside FILL, so all-ones low bits mark the last word.
    assign ret_last  = ret_fire & (&ret_cnt[OFFS-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rom_req_o  = 1'b0;
        rom_add_o  = '0;
        case (state)
            IDLE: begin
                if (rd_miss) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                rom_req_o = ~issue_cnt[OFFS];
                if (~issue_cnt[OFFS]) begin
                    rom_add_o = {tag, issue_cnt[OFFS-1:0], 2'b00};
                end
                if (ret_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && ret_fire) begin
            line_mem[ret_cnt[OFFS-1:0]] <= rom_r_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag           <= '0;
            line_valid    <= 1'b0;
            off           <= '0;
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            flush_pend    <= 1'b0;
            slv_r_valid_o <= 1'b0;
            slv_r_rdata_o <= '0;
            slv_r_opc_o   <= 1'b0;
        end else begin
            slv_r_valid_o <= 1'b0;
            if (state == IDLE) begin
                if (flush_i) begin
                    line_valid <= 1'b0;
                end
                if (wr_acc) begin
                    slv_r_valid_o <= 1'b1;
                    slv_r_opc_o   <= 1'b1;
                    slv_r_rdata_o <= '0;
                end else if (rd_hit) begin
                    slv_r_valid_o <= 1'b1;
                    slv_r_opc_o   <= 1'b0;
                    slv_r_rdata_o <= line_mem[req_offs];
                end else if (rd_miss) begin
                    tag        <= req_tag;
                    off        <= req_offs;
                    line_valid <= 1'b0;
                    issue_cnt  <= '0;
                    ret_cnt    <= '0;
                    flush_pend <= 1'b0;
                end
            end else begin
                if (flush_i) begin
                    flush_pend <= 1'b1;
                end
                if (rom_req_o && rom_gnt_i) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (ret_fire) begin
                    ret_cnt <= ret_cnt + 1'b1;
                    if (ret_cnt[OFFS-1:0] == off) begin
                        slv_r_valid_o <= 1'b1;
                        slv_r_opc_o   <= 1'b0;
                        slv_r_rdata_o <= rom_r_rdata_i;
                    end
                    // A flush seen at any point of the fill leaves the new line invalid.
                    if (ret_last) begin
                        line_valid <= ~(flush_pend | flush_i);
                        flush_pend <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_rom_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_rom_prefetch
// Function : scoreboard bench for boot_rom_prefetch with a ROM model whose
//            data equals its word address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_rom_prefetch;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        slv_req;
    logic [31:0] slv_add;
    logic        slv_wen;
    logic        slv_gnt;
    logic        slv_r_valid;
    logic [31:0] slv_rdata;
    logic        slv_opc;
    logic        rom_req;
    logic [31:0] rom_add;
    logic        rom_gnt;
    logic        rom_r_valid;
    logic [31:0] rom_rdata;

    boot_rom_prefetch #(
        .ADDR_WIDTH (32),
        .LINE_WORDS (L)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .slv_req_i     (slv_req),
        .slv_add_i     (slv_add),
        .slv_wen_i     (slv_wen),
        .slv_gnt_o     (slv_gnt),
        .slv_r_valid_o (slv_r_valid),
        .slv_r_rdata_o (slv_rdata),
        .slv_r_opc_o   (slv_opc),
        .rom_req_o     (rom_req),
        .rom_add_o     (rom_add),
        .rom_gnt_i     (rom_gnt),
        .rom_r_valid_i (rom_r_valid),
        .rom_r_rdata_i (rom_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        opc;
        int          at;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] rom_exp[$];
    int          stall_q[$];
    int          plan_stall[L];

    int tests = 0;
    int fails = 0;

    // Reference state: which line is held and since when it may be trusted.
    logic        line_ok = 1'b0;
    logic [27:0] line_tag = '0;
    int          miss_gnt = 0;
    int          last_flush = -1;
    int          ready_cyc = 0;
    int          flush_cyc = -1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ROM: grants after a planned number of stall cycles, answers one cycle after grant.
    logic        rom_last_gnt = 1'b0;
    logic [31:0] rom_last_addr = '0;
    int          rom_cur_stall = -1;

    initial begin : rom_model
        rom_gnt     = 1'b0;
        rom_r_valid = 1'b0;
        rom_rdata   = '0;
        forever begin
            @(negedge clk);
            rom_r_valid = rom_last_gnt;
            rom_rdata   = rom_last_gnt ? rom_last_addr : 32'h0;
            rom_gnt     = 1'b0;
            if (!rst_n) begin
                rom_cur_stall = -1;
                rom_exp.delete();
                stall_q.delete();
            end
            if (rom_req) begin
                if (!rst_n) begin
                    rom_gnt = 1'b1;
                end else if (rom_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rom_unexpected_req: got addr 0x%08h expected no request", rom_add);
                    rom_gnt = 1'b1;
                end else begin
                    if (rom_cur_stall < 0) begin
                        rom_cur_stall = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    end
                    chk("rom_addr", rom_add, rom_exp[0]);
                    if (rom_cur_stall > 0) begin
                        rom_cur_stall--;
                    end else begin
                        rom_gnt = 1'b1;
                        void'(rom_exp.pop_front());
                        rom_cur_stall = -1;
                    end
                end
            end
            rom_last_gnt  = rom_gnt;
            rom_last_addr = rom_add;
        end
    end

    resp_t mon_e;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && slv_r_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: got rdata 0x%08h expected no response", slv_rdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", slv_rdata, mon_e.data);
                    chk("resp_opc", {31'b0, slv_opc}, {31'b0, mon_e.opc});
                    chk("resp_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        flush = (cyc == flush_cyc);
        if (flush) last_flush = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic wen);
        int   req_cyc;
        int   g;
        int   exp_g;
        int   off;
        int   s_off;
        int   s_tot;
        logic got;
        logic hit;
        slv_req = 1'b1;
        slv_add = addr;
        slv_wen = wen;
        req_cyc = cyc;
        got     = 1'b0;
        g       = 0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = slv_gnt;
            g   = cyc;
            step();
        end
        slv_req = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: got no grant expected grant for addr 0x%08h", addr);
            return;
        end
        exp_g = (ready_cyc > req_cyc) ? ready_cyc : req_cyc;
        chk("gnt_cycle", g, exp_g);
        if (!wen) begin
            sb.push_back('{data: 32'h0, opc: 1'b1, at: g + 1});
            ready_cyc = g + 1;
        end else begin
            hit = line_ok && (addr[31:4] == line_tag) && (last_flush <= miss_gnt);
            if (hit) begin
                sb.push_back('{data: addr & ~32'd3, opc: 1'b0, at: g + 1});
                ready_cyc = g + 1;
            end else begin
                off   = int'(addr[3:2]);
                s_off = 0;
                s_tot = 0;
                for (int k = 0; k < L; k++) begin
                    stall_q.push_back(plan_stall[k]);
                    rom_exp.push_back({addr[31:4], 4'b0000} + 32'(k * 4));
                    s_tot += plan_stall[k];
                    if (k <= off) s_off += plan_stall[k];
                    plan_stall[k] = 0;
                end
                sb.push_back('{data: addr & ~32'd3, opc: 1'b0, at: g + 3 + off + s_off});
                ready_cyc = g + L + 2 + s_tot;
                line_ok   = 1'b1;
                line_tag  = addr[31:4];
                miss_gnt  = g;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] a;
        for (int k = 0; k < L; k++) plan_stall[k] = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        slv_req = 1'b1;
        slv_add = 32'h1A000008;
        slv_wen = 1'b1;
        idle(3);
        chk("rst_gnt", {31'b0, slv_gnt}, 32'h0);
        chk("rst_r_valid", {31'b0, slv_r_valid}, 32'h0);
        chk("rst_rdata", slv_rdata, 32'h0);
        chk("rst_opc", {31'b0, slv_opc}, 32'h0);
        chk("rst_rom_req", {31'b0, rom_req}, 32'h0);
        chk("rst_rom_add", rom_add, 32'h0);
        slv_req   = 1'b0;
        rst_n     = 1'b1;
        ready_cyc = cyc;
        step();

        // Cold miss, then back-to-back hits straight after the fill.
        do_txn(32'h1A000008, 1'b1);
        do_txn(32'h1A000000, 1'b1);
        do_txn(32'h1A00000C, 1'b1);
        // Writes are refused locally and leave the line intact.
        do_txn(32'h1A000004, 1'b0);
        do_txn(32'h1A000006, 1'b0);
        do_txn(32'h1A000004, 1'b1);

        // Idle flush, then refill with a three-cycle grant stall on word 2.
        flush_cyc = cyc + 1;
        idle(2);
        plan_stall[2] = 3;
        do_txn(32'h1A000008, 1'b1);
        do_txn(32'h1A000001, 1'b1);
        do_txn(32'h1A000006, 1'b1);
        do_txn(32'h1A00000B, 1'b1);
        do_txn(32'h1A00000C, 1'b1);

        // Flush during the fill: data still returned, line dropped afterwards.
        do_txn(32'h1A000024, 1'b1);
        flush_cyc = cyc + 1;
        do_txn(32'h1A000024, 1'b1);
        do_txn(32'h1A000020, 1'b1);

        // Reset in cycle 2 of a fill.
        do_txn(32'h1A000030, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        sb.delete();
        line_ok   = 1'b0;
        ready_cyc = cyc;
        chk("fillrst_gnt", {31'b0, slv_gnt}, 32'h0);
        chk("fillrst_r_valid", {31'b0, slv_r_valid}, 32'h0);
        chk("fillrst_rdata", slv_rdata, 32'h0);
        chk("fillrst_opc", {31'b0, slv_opc}, 32'h0);
        chk("fillrst_rom_req", {31'b0, rom_req}, 32'h0);
        chk("fillrst_rom_add", rom_add, 32'h0);
        do_txn(32'h1A000030, 1'b1);
        do_txn(32'h1A000034, 1'b1);

        // Randomised traffic over four lines with stalls and flushes.
        for (int i = 0; i < 250; i++) begin
            a = 32'h1A000000 + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) begin
                for (int k = 0; k < L; k++) plan_stall[k] = int'($urandom_range(0, 3));
            end
            idle(int'($urandom_range(0, 2)));
            do_txn(a, $urandom_range(0, 6) != 0);
            if ($urandom_range(0, 7) == 0) flush_cyc = cyc + int'($urandom_range(1, 5));
        end

        idle(30);
        chk("sb_drained", sb.size(), 32'h0);
        chk("rom_drained", rom_exp.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
